det_event_logger: RTL and testbench

Downstream consumer of the serial pattern detector's match output. Every cycle the detector asserts its match flag, this block records the current free-running timestamp into a small first-word-fall-through FIFO. Host logic drains the FIFO through a valid/ready port. The block also keeps a saturating total-match counter and a sticky overflow flag.

---
 rtl/det_event_logger.sv | 89 ++++++++
 tb/tb_det_event_logger.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/det_event_logger.sv
// det_event_logger
// Records the free-running timestamp into a small first-word-fall-through
// FIFO on every cycle the pattern detector asserts its match flag. The host
// drains the FIFO through a valid/ready port. A saturating total-match
// counter and a sticky overflow flag accompany the queue.
//
// Ports:
//   clk_i        rising-edge clock
//   rstn         asynchronous active-low reset
//   z_i          match flag, one event per high cycle
//   clr_i        synchronous clear of all state (highest priority)
//   evt_ready_i  consumer accepts the head entry
//   evt_valid_o  FIFO not empty
//   evt_ts_o     timestamp of the head entry (forced to 0 when empty)
//   evt_count_o  total events seen, saturating
//   ovf_o        sticky: at least one event was dropped
//   level_o      FIFO occupancy, 0..DEPTH
module det_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn,
  input  logic                       z_i,
  input  logic                       clr_i,
  input  logic                       evt_ready_i,
  output logic                       evt_valid_o,
  output logic [TS_W-1:0]            evt_ts_o,
  output logic [CNT_W-1:0]           evt_count_o,
  output logic                       ovf_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic full, pop, push, drop;

  assign full = (level == LW'(DEPTH));
  assign pop  = evt_valid_o & evt_ready_i;
  // A full FIFO can still take the event when the head leaves this cycle.
  assign push = z_i & (~full | pop);
  assign drop = z_i & full & ~pop;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      ts     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (clr_i) begin
      ts     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (z_i && (count != '1)) count <= count + 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked by level alone.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem[wr_ptr] <= ts;
  end

  assign evt_valid_o = (level != '0);
  assign evt_ts_o    = evt_valid_o ? mem[rd_ptr] : '0;
  assign evt_count_o = count;
  assign ovf_o       = ovf;
  assign level_o     = level;

endmodule

// File: tb/tb_det_event_logger.sv
module tb_det_event_logger;
  localparam int TS_W  = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TS_MOD  = 1 << TS_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rstn = 1'b0;
  logic             z_i = 1'b0;
  logic             clr_i = 1'b0;
  logic             evt_ready_i = 1'b0;
  logic             evt_valid_o;
  logic [TS_W-1:0]  evt_ts_o;
  logic [CNT_W-1:0] evt_count_o;
  logic             ovf_o;
  logic [LW-1:0]    level_o;

  det_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rstn(rstn), .z_i(z_i), .clr_i(clr_i),
    .evt_ready_i(evt_ready_i), .evt_valid_o(evt_valid_o),
    .evt_ts_o(evt_ts_o), .evt_count_o(evt_count_o), .ovf_o(ovf_o),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: queue of stored timestamps plus scalar counters.
  int exp_q[$];
  int mts, mcount;
  bit movf;
  int n_vec, n_err;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare visible state and consume popped entries.
  always @(negedge clk_i) begin
    if (rstn) begin
      check("level", int'(level_o), exp_q.size());
      check("valid", int'(evt_valid_o), int'(exp_q.size() != 0));
      check("count", int'(evt_count_o), mcount);
      check("ovf", int'(ovf_o), int'(movf));
      if (evt_valid_o && evt_ready_i && exp_q.size() != 0) begin
        check("pop_ts", int'(evt_ts_o), exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+2, returns at posedge+2.
  task automatic cycle(input bit z, input bit r, input bit c);
    int  lvl;
    bit  pop, acc;
    int  tsv;
    z_i = z; evt_ready_i = r; clr_i = c;
    lvl = exp_q.size();
    pop = (lvl != 0) && r;
    acc = z && ((lvl < DEPTH) || pop);
    tsv = mts;
    @(posedge clk_i); #1;
    if (c) begin
      exp_q.delete();
      mts = 0; mcount = 0; movf = 0;
    end else begin
      if (acc) exp_q.push_back(tsv);
      mts = (mts + 1) % TS_MOD;
      if (z && mcount < CNT_MAX) mcount++;
      if (z && !acc) movf = 1;
    end
    #1;
    z_i = 0; clr_i = 0;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases it.
  task automatic do_reset();
    @(posedge clk_i); #2;
    rstn = 0;
    #1;
    check("rst_valid", int'(evt_valid_o), 0);
    check("rst_level", int'(level_o), 0);
    check("rst_count", int'(evt_count_o), 0);
    check("rst_ovf", int'(ovf_o), 0);
    exp_q.delete();
    mts = 0; mcount = 0; movf = 0;
    @(posedge clk_i); #2;
    rstn = 1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    mts = 0; mcount = 0; movf = 0;
    #2;
    check("rst_valid0", int'(evt_valid_o), 0);
    check("rst_ts0", int'(evt_ts_o), 0);
    check("rst_level0", int'(level_o), 0);
    @(posedge clk_i); #2;
    rstn = 1;

    // Single pulse at ts=5, ready low.
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("first_ts", int'(evt_ts_o), 5);
    check("first_level", int'(level_o), 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);

    // Overflow: pulses at even ts 2..10 with ready low, then drain.
    do_reset();
    for (int i = 0; i < 11; i++) cycle(mts >= 2 && mts <= 10 && (mts % 2 == 0), 0, 0);
    check("ovf_set", int'(ovf_o), 1);
    check("ovf_head", int'(evt_ts_o), 2);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    cycle(1, 1, 0);
    check("full_pp_level", int'(level_o), DEPTH);
    check("full_pp_ovf", int'(ovf_o), 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);

    // Sustained drain with counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1, 1, 0);
    check("sat_count", int'(evt_count_o), CNT_MAX);
    check("sat_ovf", int'(ovf_o), 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);

    // Clear together with an event while holding 3 entries and ovf set.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(1, 0, 1);
    check("clr_level", int'(level_o), 0);
    check("clr_ovf", int'(ovf_o), 0);
    cycle(1, 0, 0);
    check("clr_ts0", int'(evt_ts_o), 0);
    cycle(0, 1, 0);

    // Timestamp wrap, then reset during a drain.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("wrap_ts", int'(evt_ts_o), 1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    do_reset();

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);

    @(posedge clk_i); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
